// File: rtl/audio_pkg.sv
// Register map and bit positions shared by the audio sample pacer and its bench.
package audio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_CONTROL = 3'd2;
  localparam logic [2:0] ADDR_FILL    = 3'd3;
  localparam logic [2:0] ADDR_UCNT    = 3'd4;

  localparam int ST_UNDERRUN = 0;
  localparam int ST_OVERFLOW = 1;
  localparam int ST_LOW      = 2;
  localparam int ST_EMPTY    = 3;
  localparam int ST_FULL     = 4;

  localparam int CTL_ENABLE  = 0;
  localparam int CTL_IRQ_LOW = 1;
  localparam int CTL_IRQ_ERR = 2;
  localparam int CTL_FLUSH   = 3;

  localparam int UCNT_W = 16;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead synchronous FIFO holding PCM samples; dout is always the head entry.
module audio_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [DATA_W-1:0]              din,
  input  logic                           pop,
  input  logic                           flush,
  output logic [DATA_W-1:0]              dout,
  output logic [$clog2(FIFO_DEPTH):0]    fill,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic              do_push, do_pop;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign fill  = fill_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      fill_d = fill_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/audio_sample_pacer.sv
// Avalon-MM sample pacer: buffers HPS-written PCM samples and releases one per tick_in rise.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOWMARK    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic              tick_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic              wr, push, flush, rise, pop_req, pop_ok;
  logic              underrun_evt, overflow_evt, low;
  logic              fifo_empty, fifo_full;
  logic [AW:0]       fill;
  logic [DATA_W-1:0] head;
  logic [4:0]        status;

  logic              tick_dly_q, tick_dly_d;
  logic              enable_q, enable_d;
  logic              irq_low_en_q, irq_low_en_d;
  logic              irq_err_en_q, irq_err_en_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic [DATA_W-1:0] sample_out_q, sample_out_d;
  logic              sample_valid_q, sample_valid_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  assign wr           = chipselect & ~write_n;
  assign push         = wr & (address == ADDR_DATA);
  assign flush        = wr & (address == ADDR_CONTROL) & writedata[CTL_FLUSH];
  assign rise         = tick_in & ~tick_dly_q;
  assign pop_req      = rise & enable_q;
  // A flush discards any pop that lands in the same cycle.
  assign pop_ok       = pop_req & ~fifo_empty & ~flush;
  assign underrun_evt = pop_req & fifo_empty;
  assign overflow_evt = push & fifo_full & ~pop_ok;
  assign low          = (fill < (AW+1)'(LOWMARK));
  assign status       = {fifo_full, fifo_empty, low, overflow_q, underrun_q};

  audio_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (writedata),
    .pop     (pop_req & ~flush),
    .flush   (flush),
    .dout    (head),
    .fill    (fill),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    tick_dly_d     = tick_in;
    enable_d       = enable_q;
    irq_low_en_d   = irq_low_en_q;
    irq_err_en_d   = irq_err_en_q;
    underrun_d     = underrun_q;
    overflow_d     = overflow_q;
    ucnt_d         = ucnt_q;
    sample_out_d   = pop_ok ? head : sample_out_q;
    sample_valid_d = pop_ok;
    readdata_d     = '0;

    if (wr && address == ADDR_CONTROL) begin
      enable_d     = writedata[CTL_ENABLE];
      irq_low_en_d = writedata[CTL_IRQ_LOW];
      irq_err_en_d = writedata[CTL_IRQ_ERR];
    end
    if (wr && address == ADDR_STATUS) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (underrun_evt) underrun_d = 1'b1;
    if (overflow_evt) overflow_d = 1'b1;

    if (wr && address == ADDR_UCNT) ucnt_d = '0;
    if (underrun_evt && ucnt_d != '1) ucnt_d = ucnt_d + 1'b1;

    case (address)
      ADDR_STATUS:  readdata_d = DATA_W'(status);
      ADDR_CONTROL: readdata_d = DATA_W'({irq_err_en_q, irq_low_en_q, enable_q});
      ADDR_FILL:    readdata_d = DATA_W'(fill);
      ADDR_UCNT:    readdata_d = DATA_W'(ucnt_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_dly_q     <= 1'b0;
      enable_q       <= 1'b0;
      irq_low_en_q   <= 1'b0;
      irq_err_en_q   <= 1'b0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      ucnt_q         <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      readdata_q     <= '0;
    end else begin
      tick_dly_q     <= tick_dly_d;
      enable_q       <= enable_d;
      irq_low_en_q   <= irq_low_en_d;
      irq_err_en_q   <= irq_err_en_d;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
      ucnt_q         <= ucnt_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign irq          = (irq_low_en_q & enable_q & low) | (irq_err_en_q & (underrun_q | overflow_q));

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: scenario tasks checked against a queue-based model of the pacer.
module tb_audio_sample_pacer;
  localparam int DEPTH   = 64;
  localparam int LOWMARK = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        tick_in = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  audio_sample_pacer #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .LOWMARK(LOWMARK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .tick_in      (tick_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .irq          (irq)
  );

  // Behavioural model: a sample queue plus the architectural register values.
  logic [15:0] mq[$];
  bit          m_under, m_over, m_en, m_ilow, m_ierr;
  int          m_ucnt;
  logic [15:0] m_sout;

  function automatic void m_reset();
    mq.delete();
    m_under = 0; m_over = 0; m_en = 0; m_ilow = 0; m_ierr = 0;
    m_ucnt = 0; m_sout = '0;
  endfunction

  function automatic void m_push(input logic [15:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else m_over = 1;
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
    case (a)
      3'd0: m_push(d);
      3'd1: begin m_under = 0; m_over = 0; end
      3'd2: begin
        m_en = d[0]; m_ilow = d[1]; m_ierr = d[2];
        if (d[3]) mq.delete();
      end
      3'd4: m_ucnt = 0;
      default: ;
    endcase
  endfunction

  function automatic void m_tick(input bit with_push, input logic [15:0] d, output bit ev);
    ev = 0;
    if (m_en) begin
      if (mq.size() > 0) begin
        m_sout = mq.pop_front();
        ev = 1;
      end else begin
        m_under = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
    end
    if (with_push) m_push(d);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    int f = mq.size();
    case (a)
      3'd1:    return {11'd0, f == DEPTH, f == 0, f < LOWMARK, m_over, m_under};
      3'd2:    return {13'd0, m_ierr, m_ilow, m_en};
      3'd3:    return 16'(f);
      3'd4:    return 16'(m_ucnt);
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return (m_ilow & m_en & (mq.size() < LOWMARK)) | (m_ierr & (m_under | m_over));
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    m_write(a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic do_tick(input bit with_push, input logic [15:0] d,
                         output logic v, output logic [15:0] s, output bit ev);
    @(negedge clk);
    tick_in = 1'b1;
    if (with_push) begin
      chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = d;
    end
    @(negedge clk);
    v = sample_valid; s = sample_out;
    tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    m_tick(with_push, d, ev);
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({readdata, sample_out, sample_valid, irq} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%h out=%h vld=%b irq=%b exp all 0", readdata, sample_out, sample_valid, irq);
    end
    reset_n = 1'b1;
    m_reset();
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_cmp++;
      if (rd !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, rd, m_read(3'(a)));
      end
    end
    bus_read(3'd1, rd);
    n_cmp++;
    if (rd !== 16'h000C) begin
      n_fail++;
      $display("FAIL reset_status got=%h exp=000c", rd);
    end
  endtask

  task automatic test_playback();
    logic v; logic [15:0] s, rd; bit ev;
    logic [15:0] exp_s [3] = '{16'h1111, 16'h2222, 16'h3333};
    bus_write(3'd0, 16'h1111);
    bus_write(3'd0, 16'h2222);
    bus_write(3'd0, 16'h3333);
    bus_write(3'd2, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      do_tick(0, 16'h0, v, s, ev);
      n_cmp++;
      if (v !== 1'b1 || s !== exp_s[i] || s !== m_sout) begin
        n_fail++;
        $display("FAIL playback_%0d got vld=%b out=%h exp vld=1 out=%h", i, v, s, exp_s[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse_width got=%b exp=0", sample_valid);
    end
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 16'd0) begin
      n_fail++;
      $display("FAIL playback_fill got=%0d exp=0", rd);
    end
  endtask

  task automatic test_underrun();
    logic v; logic [15:0] s, rd; bit ev;
    do_tick(0, 16'h0, v, s, ev);
    n_cmp++;
    if (v !== ev || s !== m_sout) begin
      n_fail++;
      $display("FAIL underrun_hold got vld=%b out=%h exp vld=%b out=%h", v, s, ev, m_sout);
    end
    for (int a = 1; a <= 4; a += 3) begin
      bus_read(3'(a), rd);
      n_cmp++;
      if (rd !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL underrun_reg addr=%0d got=%h exp=%h", a, rd, m_read(3'(a)));
      end
    end
    bus_write(3'd2, 16'h0005);
    n_cmp++;
    if (irq !== m_irq() || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_err_set got=%b exp=1", irq);
    end
    bus_write(3'd1, 16'h0000);
    n_cmp++;
    if (irq !== m_irq() || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_err_clear got=%b exp=0", irq);
    end
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4, rd);
    n_cmp++;
    if (rd !== 16'd0) begin
      n_fail++;
      $display("FAIL ucnt_clear got=%0d exp=0", rd);
    end
  endtask

  task automatic test_overflow();
    logic v; logic [15:0] s, rd; bit ev;
    bus_write(3'd2, 16'h0001);
    for (int i = 0; i < DEPTH + 1; i++) bus_write(3'd0, 16'($urandom));
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 16'd64) begin
      n_fail++;
      $display("FAIL overflow_fill got=%0d exp=64", rd);
    end
    bus_read(3'd1, rd);
    n_cmp++;
    if (rd !== m_read(3'd1) || rd[4:1] !== 4'b1001) begin
      n_fail++;
      $display("FAIL overflow_status got=%h exp=%h", rd, m_read(3'd1));
    end
    do_tick(1, 16'($urandom), v, s, ev);
    n_cmp++;
    if (v !== ev || s !== m_sout) begin
      n_fail++;
      $display("FAIL full_push_pop got vld=%b out=%h exp vld=%b out=%h", v, s, ev, m_sout);
    end
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 16'd64) begin
      n_fail++;
      $display("FAIL full_push_pop_fill got=%0d exp=64", rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_tick(0, 16'h0, v, s, ev);
      n_cmp++;
      if (v !== ev || s !== m_sout) begin
        n_fail++;
        $display("FAIL drain_%0d got vld=%b out=%h exp vld=%b out=%h", i, v, s, ev, m_sout);
      end
    end
    bus_write(3'd1, 16'h0000);
    bus_read(3'd1, rd);
    n_cmp++;
    if (rd !== m_read(3'd1)) begin
      n_fail++;
      $display("FAIL drained_status got=%h exp=%h", rd, m_read(3'd1));
    end
  endtask

  task automatic test_level_hold();
    logic v; logic [15:0] s, rd; bit ev;
    int pulses = 0;
    bus_write(3'd0, 16'($urandom));
    bus_write(3'd0, 16'($urandom));
    @(negedge clk);
    tick_in = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    tick_in = 1'b0;
    @(negedge clk);
    if (sample_valid) pulses++;
    m_tick(0, 16'h0, ev);
    n_cmp++;
    if (pulses !== 1 || sample_out !== m_sout) begin
      n_fail++;
      $display("FAIL level_hold got pulses=%0d out=%h exp pulses=1 out=%h", pulses, sample_out, m_sout);
    end
    bus_write(3'd2, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      do_tick(0, 16'h0, v, s, ev);
      n_cmp++;
      if (v !== 1'b0 || s !== m_sout) begin
        n_fail++;
        $display("FAIL disabled_tick_%0d got vld=%b out=%h exp vld=0 out=%h", i, v, s, m_sout);
      end
    end
    for (int a = 1; a <= 4; a++) begin
      bus_read(3'(a), rd);
      n_cmp++;
      if (rd !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL disabled_reg addr=%0d got=%h exp=%h", a, rd, m_read(3'(a)));
      end
    end
  endtask

  task automatic test_flush_and_reset();
    logic v; logic [15:0] s, rd; bit ev;
    bus_write(3'd2, 16'h0001);
    while (mq.size() < 20) bus_write(3'd0, 16'($urandom));
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 16'd20) begin
      n_fail++;
      $display("FAIL pre_flush_fill got=%0d exp=20", rd);
    end
    bus_write(3'd2, 16'h0009);
    for (int a = 1; a <= 3; a++) begin
      bus_read(3'(a), rd);
      n_cmp++;
      if (rd !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL post_flush addr=%0d got=%h exp=%h", a, rd, m_read(3'(a)));
      end
    end
    for (int i = 0; i < 3; i++) bus_write(3'd0, 16'($urandom) | 16'h0001);
    do_tick(0, 16'h0, v, s, ev);
    n_cmp++;
    if (v !== ev || s !== m_sout) begin
      n_fail++;
      $display("FAIL post_flush_pop got vld=%b out=%h exp vld=%b out=%h", v, s, ev, m_sout);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (sample_out !== 16'h0 || sample_valid !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got out=%h vld=%b irq=%b exp 0", sample_out, sample_valid, irq);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_fill got=%0d exp=0", rd);
    end
  endtask

  task automatic test_random();
    logic v; logic [15:0] s, rd; bit ev;
    int r;
    bus_write(3'd2, 16'($urandom_range(0, 3) << 1) | 16'h0001);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        bus_write(3'd0, 16'($urandom));
      end else if (r <= 7) begin
        do_tick(r == 7, 16'($urandom), v, s, ev);
        n_cmp++;
        if (v !== ev || s !== m_sout) begin
          n_fail++;
          $display("FAIL rand_tick_%0d got vld=%b out=%h exp vld=%b out=%h", i, v, s, ev, m_sout);
        end
      end else if (r == 8) begin
        r = $urandom_range(0, 7);
        bus_read(3'(r), rd);
        n_cmp++;
        if (rd !== m_read(3'(r))) begin
          n_fail++;
          $display("FAIL rand_read_%0d addr=%0d got=%h exp=%h", i, r, rd, m_read(3'(r)));
        end
      end else begin
        bus_write(3'd1, 16'h0000);
      end
      n_cmp++;
      if (irq !== m_irq()) begin
        n_fail++;
        $display("FAIL rand_irq_%0d got=%b exp=%b", i, irq, m_irq());
      end
    end
    for (int a = 1; a <= 4; a++) begin
      bus_read(3'(a), rd);
      n_cmp++;
      if (rd !== m_read(3'(a))) begin
        n_fail++;
        $display("FAIL rand_final addr=%0d got=%h exp=%h", a, rd, m_read(3'(a)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_playback();
    test_underrun();
    test_overflow();
    test_level_hold();
    test_flush_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
